// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller for a DDS phase accumulator: steps a tuning word
// between two limits with a programmable dwell, either once upward or as a triangle.
module dds_sweep_ctrl #(
  parameter int FW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] fword,
  output logic          fword_upd,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fword_q, fword_d;
  logic          fword_upd_q, fword_upd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [FW-1:0] lo_q, lo_d;
  logic [FW-1:0] hi_q, hi_d;
  logic [FW-1:0] step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic [FW:0]   up_sum;
  logic [FW:0]   dn_diff;
  logic [FW-1:0] up_next;
  logic [FW-1:0] dn_next;
  logic          cfg_ok;
  logic          expired;

  // One extra bit on both sides of the limit arithmetic turns wrap into a clamp.
  assign up_sum  = {1'b0, fword_q} + {1'b0, step_q};
  assign dn_diff = {1'b0, fword_q} - {1'b0, step_q};
  assign up_next = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[FW-1:0];
  assign dn_next = (dn_diff[FW] || (dn_diff[FW-1:0] <= lo_q)) ? lo_q : dn_diff[FW-1:0];
  assign cfg_ok  = (f_step != '0) && (f_start < f_stop);
  assign expired = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    fword_d     = fword_q;
    fword_upd_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    step_d      = step_q;
    dwell_d     = dwell_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            mode_d      = mode;
            lo_d        = f_start;
            hi_d        = f_stop;
            step_d      = f_step;
            dwell_d     = dwell;
            fword_d     = f_start;
            fword_upd_d = 1'b1;
            busy_d      = 1'b1;
            cnt_d       = dwell;
            state_d     = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP, DOWN: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (!expired) begin
          cnt_d = cnt_q - DW'(1);
        end else begin
          cnt_d = dwell_q;
          if (state_q == UP) begin
            if (fword_q < hi_q) begin
              fword_d     = up_next;
              fword_upd_d = 1'b1;
            end else if (!mode_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d     = DOWN;
              fword_d     = dn_next;
              fword_upd_d = 1'b1;
            end
          end else begin
            // Bottom of the triangle turns around using the same clamped increment.
            if (fword_q > lo_q) begin
              fword_d     = dn_next;
              fword_upd_d = 1'b1;
            end else begin
              state_d     = UP;
              fword_d     = up_next;
              fword_upd_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fword_q     <= '0;
      fword_upd_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      fword_q     <= fword_d;
      fword_upd_q <= fword_upd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
    end
  end

  assign fword     = fword_q;
  assign fword_upd = fword_upd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a list-based sweep model predicts every
// fword_upd/done/err pulse with its cycle, and a negedge monitor consumes them.
module tb_dds_sweep_ctrl;

  localparam int FW  = 32;
  localparam int DW  = 16;
  localparam int INF = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [FW-1:0] f_start = '0;
  logic [FW-1:0] f_stop = '0;
  logic [FW-1:0] f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [FW-1:0] fword;
  logic          fword_upd;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct {
    int          kind;
    logic [31:0] value;
    int          cycle;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] exp_fword = '0;
  int          busy_from = 0;
  int          busy_to = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .fword(fword), .fword_upd(fword_upd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " fword"}, fword, 0);
    check_output({tag, " fword_upd"}, fword_upd, 0);
    check_output({tag, " busy"}, busy, 0);
    check_output({tag, " done"}, done, 0);
    check_output({tag, " err"}, err, 0);
  endtask

  // Walk the list of tuning words a sweep visits; value i appears dw+1 cycles after value i-1.
  task automatic model_sweep(input bit m, input longint fs, input longint fe, input longint st,
                             input int dw, input int n, input int s, output int end_cyc);
    longint v;
    bit     going_up;
    int     t;
    v = fs;
    going_up = 1'b1;
    t = n;
    forever begin
      if (t >= s) begin
        end_cyc = s;
        return;
      end
      exp_q.push_back('{0, v[31:0], t});
      t += dw + 1;
      if (going_up) begin
        if (v == fe) begin
          if (!m) begin
            if (t < s) exp_q.push_back('{1, 32'h0, t});
            end_cyc = (t < s) ? t : s;
            return;
          end
          going_up = 1'b0;
          v = (fe - st < fs) ? fs : fe - st;
        end else begin
          v = (v + st > fe) ? fe : v + st;
        end
      end else begin
        if (v == fs) begin
          going_up = 1'b1;
          v = (fs + st > fe) ? fe : fs + st;
        end else begin
          v = (v - st < fs) ? fs : v - st;
        end
      end
    end
  endtask

  // Issue one start, optionally abort it with stop (or reset) abort_after cycles later,
  // scrambling the inputs and poking start while the sweep runs.
  task automatic apply_stimulus(input bit m, input logic [31:0] fs, input logic [31:0] fe,
                                input logic [31:0] st, input logic [15:0] dw,
                                input int abort_after, input bit use_reset);
    int n, s, end_cyc;
    n = cyc + 1;
    s = (abort_after < 0) ? INF : n + abort_after;
    if (st != 0 && fs < fe) begin
      model_sweep(m, longint'(fs), longint'(fe), longint'(st), int'(dw), n, s, end_cyc);
      busy_from = n;
      busy_to = end_cyc;
    end else begin
      exp_q.push_back('{2, 32'h0, n});
      end_cyc = n;
    end
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < end_cyc + 2) begin
      if (abort_after >= 0 && cyc + 1 == s) begin
        if (use_reset) begin
          #2 rst_n = 1'b0;
          #1 check_all_zero("mid-sweep reset");
          exp_q.delete();
          busy_to = 0;
          @(negedge clk);
          @(negedge clk);
          #2 rst_n = 1'b1;
          return;
        end
        stop = 1'b1;
      end else if (cyc + 1 < end_cyc && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
      end
      mode = 1'($urandom); f_start = $urandom; f_stop = $urandom;
      f_step = $urandom; dwell = 16'($urandom);
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
    end
    check_output("expected events all seen", exp_q.size(), 0);
  endtask

  // Monitor: every output pulse must match the next predicted event, kind and cycle.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (!rst_n) begin
      exp_fword = '0;
    end else begin
      if (fword_upd || done || err) begin
        check_output("pulses exclusive", int'(fword_upd) + int'(done) + int'(err), 1);
        check_output("pulse was expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          kind = fword_upd ? 0 : (done ? 1 : 2);
          check_output("pulse kind", kind, e.kind);
          check_output("pulse cycle", cyc, e.cycle);
          if (e.kind == 0) exp_fword = e.value;
        end
      end
      check_output("fword", fword, exp_fword);
      check_output("busy", busy, (cyc >= busy_from) && (cyc < busy_to));
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fs, fe, st;
    bit          m, big;
    int          span, ab;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    check_all_zero("reset held");
    #2 rst_n = 1'b1;

    apply_stimulus(1'b0, 32'd100, 32'd130, 32'd10, 16'd2, -1, 1'b0);
    apply_stimulus(1'b0, 32'd100, 32'd125, 32'd10, 16'd0, -1, 1'b0);
    apply_stimulus(1'b0, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h80, 16'd0, -1, 1'b0);
    apply_stimulus(1'b1, 32'd100, 32'd130, 32'd10, 16'd1, 9, 1'b0);
    apply_stimulus(1'b0, 32'd100, 32'd130, 32'd0, 16'd1, -1, 1'b0);
    apply_stimulus(1'b0, 32'd200, 32'd100, 32'd10, 16'd1, -1, 1'b0);
    apply_stimulus(1'b1, 32'd5, 32'd5, 32'd1, 16'd0, -1, 1'b0);

    // start together with stop in idle does nothing, valid config or not
    mode = 1'b0; f_start = 32'd10; f_stop = 32'd20; f_step = 32'd1; dwell = 16'd0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check_output("start+stop ignored", exp_q.size(), 0);

    apply_stimulus(1'b1, 32'd100, 32'd130, 32'd10, 16'd1, 11, 1'b1);
    apply_stimulus(1'b1, 32'd100, 32'd130, 32'd10, 16'd1, 16, 1'b0);

    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom);
      big = ($urandom_range(0, 3) == 0);
      span = $urandom_range(1, 60);
      if (big) begin
        fe = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        st = 32'($urandom_range(1, 80));
      end else begin
        fe = 32'($urandom_range(100, 1000));
        st = 32'($urandom_range(1, 30));
      end
      fs = fe - 32'(span);
      case ($urandom_range(0, 7))
        0: st = 32'h0;
        1: fs = fe + 32'($urandom_range(0, 20)) - (big ? 32'd20 : 32'd0) + (big ? 32'd0 : 32'd0);
        default: ;
      endcase
      if (m) ab = $urandom_range(1, 60);
      else ab = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 40);
      apply_stimulus(m, fs, fe, st, 16'($urandom_range(0, 3)), ab, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001: Parameter FW, default 32; width of the frequency tuning words (phase-accumulator increment).
REQ-002: Parameter DW, default 16; width of the dwell counter.
REQ-003: clk  input  1  system clock, 100 MHz; the DDS accumulators are clocked on the same clk.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: start  input  1  single-cycle request to begin a sweep.
REQ-006: stop  input  1  single-cycle request to abort a sweep.
REQ-007: mode  input  1  0 = single up-sweep; 1 = continuous triangle (up/down).
REQ-008: f_start  input  FW  lower tuning word.
REQ-009: f_stop  input  FW  upper tuning word.
REQ-010: f_step  input  FW  tuning-word increment per step.
REQ-011: dwell  input  DW  extra hold cycles per step; each value is held dwell+1 cycles.
REQ-012: fword  output  FW  tuning word driven to the DDS phase accumulator.
REQ-013: fword_upd  output  1  one-cycle pulse in the cycle fword takes a new value.
REQ-014: busy  output  1  high while a sweep is active.
REQ-015: done  output  1  one-cycle pulse on normal completion of a mode-0 sweep.
REQ-016: err  output  1  one-cycle pulse when start is rejected for an invalid configuration.

Function
REQ-017: The FSM SHALL have the states IDLE, UP and DOWN; fword, busy and all pulses SHALL be registered.
REQ-018: In IDLE, start=1 with f_step!=0 and f_start<f_stop SHALL latch mode, f_start, f_stop, f_step and dwell.
  - On the next cycle: fword=f_start, fword_upd=1, busy=1, state UP, dwell counter=dwell.
  - Inputs changing during a sweep SHALL have no effect.
REQ-019: In IDLE, start=1 with f_step==0 or f_start>=f_stop SHALL pulse err on the next cycle; state stays IDLE, busy=0 and fword is unchanged.
REQ-020: In UP or DOWN the dwell counter SHALL decrement each cycle; the cycle in which it reads 0 is the expiry cycle, so each value is held exactly dwell+1 cycles.
REQ-021: At UP expiry with fword<f_stop:
  - fword SHALL become min(fword+f_step, f_stop), with the sum computed FW+1 bits wide so that overflow clamps to f_stop and never wraps.
  - fword_upd=1; the counter reloads.
REQ-022: At UP expiry with fword==f_stop:
  - mode 0: state IDLE, busy=0 and done=1 on the next cycle; fword holds f_stop.
  - mode 1: state DOWN; fword=max(f_stop-f_step, f_start), computed FW+1 bits wide so that underflow clamps; fword_upd=1; the counter reloads.
REQ-023: At DOWN expiry with fword>f_start: fword SHALL become max(fword-f_step, f_start); fword_upd=1; the counter reloads.
REQ-024: At DOWN expiry with fword==f_start: state UP; fword=min(f_start+f_step, f_stop); fword_upd=1; the counter reloads.
REQ-025: stop=1 in UP or DOWN SHALL force IDLE on the next cycle.
  - busy=0; done is not pulsed; fword holds its current value; fword_upd=0.
REQ-026: stop=1 SHALL take priority over start and over any same-cycle expiry; in IDLE, start and stop in the same cycle SHALL be ignored (no err).
REQ-027: start while busy=1 SHALL be ignored.
REQ-028: done, err and fword_upd SHALL each be high for exactly one cycle per event and SHALL never be high simultaneously with each other.

Reset
REQ-029: While rst_n=0, the block SHALL hold: state IDLE, fword=0, fword_upd=0, busy=0, done=0, err=0, dwell counter=0.
REQ-030: Reset asserted mid-sweep SHALL abort immediately with no done or err pulse.
REQ-031: After rst_n deasserts, the block SHALL accept start from the first rising clk edge.

Verification
REQ-032: mode=0, f_start=100, f_stop=130, f_step=10, dwell=2 -> fword 100,110,120,130, each held 3 cycles with fword_upd on each change; done pulses 3 cycles after 130 appears, together with busy falling.
REQ-033: mode=0, f_start=100, f_stop=125, f_step=10, dwell=0 -> fword 100,110,120,125 on consecutive cycles; done one cycle later.
REQ-034: f_start=0xFFFFFF00, f_stop=0xFFFFFFF0, f_step=0x80, dwell=0 -> fword 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFF0 with no wrap to low values.
REQ-035: mode=1, f_start=100, f_stop=130, f_step=10, dwell=1 -> fword 100,110,120,130,120,110,100,110,..., 2 cycles per value; stop during 120 on the way down -> busy=0 next cycle, fword stays 120, no done.
REQ-036: f_step=0, or f_start=200 with f_stop=100, then start -> err pulse 1 cycle later; busy=0; fword unchanged.
REQ-037: rst_n=0 during a mode-1 sweep -> all outputs 0 immediately; a new start after release sweeps correctly from f_start.
